regfile_dump_reader: RTL and testbench

//  Debug/trace reader for the processor register file. On a start pulse it walks an

---
 rtl/regfile_dump_reader_pkg.sv | 16 +
 rtl/regfile_dump_reader_if.sv | 34 +++
 rtl/regfile_dump_reader.sv | 138 +++++++++++++
 tb/tb_regfile_dump_reader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM state encoding and
// default address/data widths, which match the register file they read.
package regfile_dump_reader_pkg;

    localparam int ADDR_LEN_DEF = 4;
    localparam int DATA_LEN_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_CKSUM = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Bundle of the dump reader's control, register-file read port and beat stream.
// The master side is the reader; the slave side is core/regfile/trace sink.
interface regfile_dump_reader_if
    import regfile_dump_reader_pkg::*;
#(
    parameter int ADDR_LEN = ADDR_LEN_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF
) ();

    logic                start;
    logic [ADDR_LEN-1:0] first_addr;
    logic [ADDR_LEN-1:0] last_addr;
    logic [ADDR_LEN-1:0] rd_addr;
    logic [DATA_LEN-1:0] rd_data;
    logic                hold_req;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [ADDR_LEN-1:0] out_addr;
    logic [DATA_LEN-1:0] out_data;
    logic                out_last;
    logic                done;

    modport master (
        input  start, first_addr, last_addr, rd_data, out_ready,
        output rd_addr, hold_req, busy, out_valid, out_addr, out_data, out_last, done
    );

    modport slave (
        output start, first_addr, last_addr, rd_data, out_ready,
        input  rd_addr, hold_req, busy, out_valid, out_addr, out_data, out_last, done
    );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a register range (with wrap), reads each register and streams {addr,data} beats.
// Optional trailing XOR checksum beat when REGDUMP_CKSUM_EN is defined.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int ADDR_LEN = ADDR_LEN_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    regfile_dump_reader_if.master bus
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_LEN-1:0] r_cur;
    logic [ADDR_LEN-1:0] r_end;
    logic [ADDR_LEN-1:0] r_out_addr;
    logic [DATA_LEN-1:0] r_out_data;
    logic                r_out_last;
    logic                r_busy;
`ifdef REGDUMP_CKSUM_EN
    logic [DATA_LEN-1:0] r_cksum;
`endif

    logic w_accept;
    logic w_fetch;
    logic w_xfer;
    logic w_at_end;

    assign w_at_end = (r_cur == r_end);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_fetch  = 1'b0;
        w_xfer   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_fetch = 1'b1;
                w_next  = ST_SEND;
            end
            ST_SEND: begin
                if (bus.out_ready) begin
                    w_xfer = 1'b1;
                    if (!w_at_end) w_next = ST_FETCH;
`ifdef REGDUMP_CKSUM_EN
                    else w_next = ST_CKSUM;
`else
                    else w_next = ST_DONE;
`endif
                end
            end
`ifdef REGDUMP_CKSUM_EN
            ST_CKSUM: begin
                if (bus.out_ready) w_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // busy/hold_req are registered from the next state so they rise the cycle after acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur      <= '0;
            r_end      <= '0;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
`ifdef REGDUMP_CKSUM_EN
            r_cksum    <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_cur <= bus.first_addr;
                r_end <= bus.last_addr;
`ifdef REGDUMP_CKSUM_EN
                r_cksum <= '0;
`endif
            end
            if (w_fetch) begin
                r_out_addr <= r_cur;
                r_out_data <= bus.rd_data;
`ifdef REGDUMP_CKSUM_EN
                r_out_last <= 1'b0;
                r_cksum    <= r_cksum ^ bus.rd_data;
`else
                r_out_last <= w_at_end;
`endif
            end
            // The range end is not advanced past, so rd_addr keeps the last register afterwards
            if (w_xfer) begin
                if (!w_at_end) begin
                    r_cur <= r_cur + ADDR_LEN'(1);
                end
`ifdef REGDUMP_CKSUM_EN
                else begin
                    r_out_addr <= '0;
                    r_out_data <= r_cksum;
                    r_out_last <= 1'b1;
                end
`endif
            end
        end
    end

    assign bus.rd_addr   = r_cur;
    assign bus.hold_req  = r_busy;
    assign bus.busy      = r_busy;
    assign bus.out_valid = (r_state == ST_SEND) || (r_state == ST_CKSUM);
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a preloaded r[i] = i*0x11111111 register file.
`timescale 1ns/1ps
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic [DW-1:0] rf [16];

    regfile_dump_reader_if #(.ADDR_LEN(AW), .DATA_LEN(DW)) bus ();

    regfile_dump_reader #(.ADDR_LEN(AW), .DATA_LEN(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.rd_data = rf[bus.rd_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},   64'(bus.out_valid), 64'd0);
        chk({tag, "_hold"},    64'(bus.hold_req),  64'd0);
        chk({tag, "_busy"},    64'(bus.busy),      64'd0);
        chk({tag, "_done"},    64'(bus.done),      64'd0);
        chk({tag, "_last"},    64'(bus.out_last),  64'd0);
        chk({tag, "_addr"},    64'(bus.out_addr),  64'd0);
        chk({tag, "_data"},    64'(bus.out_data),  64'd0);
        chk({tag, "_rd_addr"}, 64'(bus.rd_addr),   64'd0);
    endtask

    task automatic dump(input logic [3:0] first, input logic [3:0] last,
                        input int stall_idx, input int stall_len, input bit mid_start);
        int          n;
        int          t0;
        int          w;
        int          extra;
        logic [3:0]  d;
        logic [3:0]  ea;
        logic [31:0] ed;
        logic [31:0] exp_ck;
        d      = last - first;
        n      = int'(d) + 1;
        exp_ck = '0;
        extra  = 0;
`ifdef REGDUMP_CKSUM_EN
        extra  = 1;
`endif
        bus.first_addr = first;
        bus.last_addr  = last;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t0 = cyc;
        chk("busy_after_start", 64'(bus.busy),     64'd1);
        chk("hold_after_start", 64'(bus.hold_req), 64'd1);
        chk("rd_addr_fetch",    64'(bus.rd_addr),  64'(first));
        if (mid_start) begin
            bus.first_addr = 4'h0;
            bus.last_addr  = 4'hF;
            bus.start      = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            ea = first + 4'(k);
            ed = 32'(ea) * 32'h11111111;
            w  = 0;
            while (bus.out_valid !== 1'b1 && w < 10) begin
                @(negedge clk);
                w++;
            end
            if (bus.out_valid !== 1'b1) begin
                chk("beat_timeout", 64'(bus.out_valid), 64'd1);
                return;
            end
            chk("beat_addr", 64'(bus.out_addr), 64'(ea));
            chk("beat_data", 64'(bus.out_data), 64'(ed));
`ifdef REGDUMP_CKSUM_EN
            chk("beat_last", 64'(bus.out_last), 64'd0);
`else
            chk("beat_last", 64'(bus.out_last), 64'(k == n - 1));
`endif
            chk("hold_during", 64'(bus.hold_req), 64'd1);
            exp_ck = exp_ck ^ ed;
            if (k == stall_idx) begin
                bus.out_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_valid", 64'(bus.out_valid), 64'd1);
                    chk("stall_addr",  64'(bus.out_addr),  64'(ea));
                    chk("stall_data",  64'(bus.out_data),  64'(ed));
                end
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            if (!(extra == 1 && k == n - 1))
                chk("valid_drops_after_xfer", 64'(bus.out_valid), 64'd0);
        end
`ifdef REGDUMP_CKSUM_EN
        chk("ck_valid", 64'(bus.out_valid), 64'd1);
        chk("ck_addr",  64'(bus.out_addr),  64'd0);
        chk("ck_data",  64'(bus.out_data),  64'(exp_ck));
        chk("ck_last",  64'(bus.out_last),  64'd1);
        @(negedge clk);
`endif
        chk("done_pulse",   64'(bus.done),      64'd1);
        chk("busy_in_done", 64'(bus.busy),      64'd1);
        chk("valid_in_done", 64'(bus.out_valid), 64'd0);
        chk("dump_cycles",  64'(cyc - t0),
            64'(2 * n + ((stall_idx >= 0) ? stall_len : 0) + extra));
        @(negedge clk);
        chk("done_cleared", 64'(bus.done),     64'd0);
        chk("busy_idle",    64'(bus.busy),     64'd0);
        chk("hold_idle",    64'(bus.hold_req), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'(i) * 32'h11111111;
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.first_addr = 4'h0;
        bus.last_addr  = 4'h0;
        bus.out_ready  = 1'b1;

        // 1: reset and idle
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_all_zero("idle");

        // 2: full range
        dump(4'd0, 4'd15, -1, 0, 1'b0);

        // 3: wrapping range with a 3-cycle stall on the second beat
        dump(4'd14, 4'd1, 1, 3, 1'b0);

        // 4: single register, start pulsed mid-dump
        dump(4'd5, 4'd5, -1, 0, 1'b1);

        // 5: reset during SEND, then a fresh full wrapping dump
        bus.first_addr = 4'd0;
        bus.last_addr  = 4'd15;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        chk("pre_reset_addr",  64'(bus.out_addr),  64'd2);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", 64'(bus.busy), 64'd0);
        dump(4'd3, 4'd2, -1, 0, 1'b0);

`ifdef REGDUMP_CKSUM_EN
        // 6: checksum beat
        dump(4'd1, 4'd3, -1, 0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
